ecc_scrubber: RTL

Background memory scrubber for Hamming-protected storage. It walks an address range, reads each stored data+parity word, and recomputes the syndrome. Single-bit errors are corrected and written back; uncorrectable syndromes are counted and logged. It sits beside the Hamming-protected buffers on the read side, sharing their memory port with the functional path through a pause input.

---
 rtl/ecc_pkg.sv | 45 ++++
 rtl/ecc_scrub_corr.sv | 47 ++++
 rtl/ecc_scrubber.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ecc_pkg.sv
// Shared types and elaboration-time helpers for the Hamming scrubber.
// The codeword helpers describe where each data/parity bit sits (positions 1..DW+PW).
package ecc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    CHECK,
    WR_REQ,
    NEXT,
    DONE
  } scrub_state_t;

  // Smallest PW with 2**PW >= DW+PW+1.
  function automatic int get_parity_width(input int dw);
    int pw = 0;
    for (int p = 1; p < 31; p++) begin
      if (pw == 0 && (1 << p) >= dw + p + 1) pw = p;
    end
    return pw;
  endfunction

  function automatic bit is_pow2(input int p);
    return (p > 0) && ((p & (p - 1)) == 0);
  endfunction

  function automatic int log2_floor(input int p);
    int r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((p >> i) > 1) r = i + 1;
    end
    return r;
  endfunction

  // Data bits fill the non-power-of-two positions in ascending order.
  function automatic int data_index(input int p);
    int n = 0;
    for (int i = 1; i < p; i++) begin
      if (!is_pow2(i)) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/ecc_scrub_corr.sv
// Combinational Hamming syndrome and single-bit correction for one stored word.
// The syndrome is the XOR of the indices of all set positions, stored parity included.
module ecc_scrub_corr
  import ecc_pkg::*;
#(
  parameter int DW = 10,
  parameter int PW = 4
) (
  input  logic [DW-1:0] data,
  input  logic [PW-1:0] parity,
  output logic [PW-1:0] syndrome,
  output logic [DW-1:0] corr_data,
  output logic [PW-1:0] corr_parity,
  output logic          uncorr
);

  localparam int N = DW + PW;

  logic [N:1] cw;
  logic [N:1] fixed;

  for (genvar p = 1; p <= N; p++) begin : g_pos
    if (is_pow2(p)) begin : g_par
      assign cw[p]                        = parity[log2_floor(p)];
      assign corr_parity[log2_floor(p)]   = fixed[p];
    end else begin : g_dat
      assign cw[p]                        = data[data_index(p)];
      assign corr_data[data_index(p)]     = fixed[p];
    end
    assign fixed[p] = cw[p] ^ (syndrome == PW'(p));
  end

  for (genvar k = 0; k < PW; k++) begin : g_syn
    logic [N:1] sel;
    for (genvar p = 1; p <= N; p++) begin : g_sel
      if (((p >> k) & 1) == 1) begin : g_on
        assign sel[p] = cw[p];
      end else begin : g_off
        assign sel[p] = 1'b0;
      end
    end
    assign syndrome[k] = ^sel;
  end

  assign uncorr = (syndrome > PW'(N));

endmodule

// File: rtl/ecc_scrubber.sv
// Background scrubber: walks an address range, corrects single-bit errors by
// write-back, and counts/logs every nonzero syndrome.
//
// state   | meaning
// IDLE    | waiting for i_start
// RD_REQ  | issue read at base+index unless paused
// RD_WAIT | single outstanding read, wait for rvalid
// CHECK   | evaluate syndrome on registered word
// WR_REQ  | hold write-back until acked
// NEXT    | advance index, finish when range exhausted
// DONE    | pulse o_done, drop o_busy
module ecc_scrubber
  import ecc_pkg::*;
#(
  parameter  int DW   = 10,
  parameter  int AW   = 8,
  parameter  int CNTW = 16,
  localparam int PW   = get_parity_width(DW)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_start,
  input  logic [AW-1:0]   i_base,
  input  logic [AW:0]     i_count,
  input  logic            i_pause,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_mem_rreq,
  output logic [AW-1:0]   o_mem_raddr,
  input  logic            i_mem_rvalid,
  input  logic [DW-1:0]   i_mem_rdata,
  input  logic [PW-1:0]   i_mem_rparity,
  output logic            o_mem_wreq,
  output logic [AW-1:0]   o_mem_waddr,
  output logic [DW-1:0]   o_mem_wdata,
  output logic [PW-1:0]   o_mem_wparity,
  input  logic            i_mem_wack,
  output logic [CNTW-1:0] o_corr_cnt,
  output logic [CNTW-1:0] o_uncorr_cnt,
  output logic [AW-1:0]   o_err_addr,
  output logic [PW-1:0]   o_err_pos
);

  scrub_state_t  state;
  logic [AW-1:0] base;
  logic [AW:0]   count;
  logic [AW:0]   index;
  logic [AW:0]   idx_nxt;
  logic [DW-1:0] rd_data;
  logic [PW-1:0] rd_parity;

  logic [PW-1:0] syn;
  logic [DW-1:0] fix_data;
  logic [PW-1:0] fix_parity;
  logic          syn_uncorr;

  ecc_scrub_corr #(
    .DW(DW),
    .PW(PW)
  ) u_corr (
    .data        (rd_data),
    .parity      (rd_parity),
    .syndrome    (syn),
    .corr_data   (fix_data),
    .corr_parity (fix_parity),
    .uncorr      (syn_uncorr)
  );

  assign idx_nxt = index + (AW+1)'(1);

  // The read strobe follows i_pause directly so a word costs only four cycles.
  assign o_mem_rreq = (state == RD_REQ) && !i_pause;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      base          <= '0;
      count         <= '0;
      index         <= '0;
      rd_data       <= '0;
      rd_parity     <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_mem_raddr   <= '0;
      o_mem_wreq    <= 1'b0;
      o_mem_waddr   <= '0;
      o_mem_wdata   <= '0;
      o_mem_wparity <= '0;
      o_corr_cnt    <= '0;
      o_uncorr_cnt  <= '0;
      o_err_addr    <= '0;
      o_err_pos     <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            base        <= i_base;
            count       <= i_count;
            index       <= '0;
            o_mem_raddr <= i_base;
            o_busy      <= 1'b1;
            state       <= (i_count == '0) ? DONE : RD_REQ;
          end
        end
        RD_REQ: begin
          if (!i_pause) state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (i_mem_rvalid) begin
            rd_data   <= i_mem_rdata;
            rd_parity <= i_mem_rparity;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (syn == '0) begin
            state <= NEXT;
          end else if (syn_uncorr) begin
            if (o_uncorr_cnt != {CNTW{1'b1}}) o_uncorr_cnt <= o_uncorr_cnt + CNTW'(1);
            o_err_addr <= o_mem_raddr;
            o_err_pos  <= syn;
            state      <= NEXT;
          end else begin
            if (o_corr_cnt != {CNTW{1'b1}}) o_corr_cnt <= o_corr_cnt + CNTW'(1);
            o_err_addr    <= o_mem_raddr;
            o_err_pos     <= syn;
            o_mem_wreq    <= 1'b1;
            o_mem_waddr   <= o_mem_raddr;
            o_mem_wdata   <= fix_data;
            o_mem_wparity <= fix_parity;
            state         <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (i_mem_wack) begin
            o_mem_wreq <= 1'b0;
            state      <= NEXT;
          end
        end
        NEXT: begin
          index       <= idx_nxt;
          o_mem_raddr <= base + idx_nxt[AW-1:0];
          state       <= (idx_nxt == count) ? DONE : RD_REQ;
        end
        DONE: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
